if_fetch_buf: RTL and testbench
===============================

Name: if_fetch_buf

Overview:
- Parametrised instruction-fetch stage. Replaces the fixed PC register plus IF/ID latch in the pipeline top with a fetch unit that tolerates variable ROM latency.
- Issues pipelined ROM requests and buffers returned instructions, each with its PC, in an in-order ring of DEPTH entries.
- Presents instructions to ID through a valid/ready handshake.
- Supports stall from ID and a branch/exception redirect that flushes the buffer and discards in-flight responses.

Parameters:
ADDR_W, 32, PC and ROM address width
DATA_W, 32, instruction width
DEPTH, 4, ring entries and maximum outstanding requests; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
rom_req_o  out  1  fetch request valid
rom_addr_o  out  ADDR_W  fetch address
rom_gnt_i  in  1  ROM accepted request this cycle (only meaningful with rom_req_o)
rom_rvalid_i  in  1  instruction returned this cycle; responses return in request order
rom_rdata_i  in  DATA_W  returned instruction
id_valid_o  out  1  buffered instruction available
id_pc_o  out  ADDR_W  PC of head instruction
id_inst_o  out  DATA_W  head instruction
id_ready_i  in  1  ID consumes head this cycle
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  ADDR_W  new fetch PC
count_o  out  $clog2(DEPTH)+1  entries allocated (in flight plus filled)

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; alloc/fill/head pointers=0; drop_cnt=0.
  - rom_req_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0.
  - First request occurs in the first cycle after rst deasserts.
- Pointers: alloc, fill and head each carry one extra wrap bit.
  - inflight = alloc-fill; filled = fill-head; count_o = alloc-head.
- Issue:
  - rom_req_o = !redirect_i && count_o<DEPTH && (drop_cnt+inflight)<DEPTH.
  - rom_addr_o = fetch_pc. Held stable until granted, because fetch_pc changes only on grant or redirect.
  - On rom_req_o && rom_gnt_i: entry[alloc].pc<=fetch_pc; alloc++; fetch_pc+=PC_STEP (modulo 2^ADDR_W).
- Return:
  - On rom_rvalid_i with drop_cnt>0: discard and decrement drop_cnt.
  - Otherwise, if inflight>0: entry[fill].inst<=rom_rdata_i; fill++.
  - rvalid with inflight=0 and drop_cnt=0 is a protocol error: ignore it, no state change.
- Output:
  - id_valid_o = filled>0; id_pc_o/id_inst_o = entry[head], combinational from registered ring state.
  - id_pc_o/id_inst_o are 0 when id_valid_o=0.
  - On id_valid_o && id_ready_i: head++.
- Latency: zero-wait ROM (gnt same cycle, rvalid next cycle) gives id_valid_o 2 cycles after the request cycle. Sustained throughput is 1 instruction/cycle when id_ready_i=1.
- Stall: id_ready_i=0 holds head. Issue continues until count_o=DEPTH, then rom_req_o=0. Entry contents never change while buffered.
- Full/empty:
  - count_o=DEPTH blocks issue; a same-cycle pop does not unblock the same cycle.
  - filled=0 gives id_valid_o=0.
  - Simultaneous pop, grant and rvalid are all legal in one cycle.
- Redirect (highest priority):
  - In the redirect cycle: rom_req_o=0; pop, grant and fill are suppressed.
  - Next state: fetch_pc=redirect_pc_i; alloc=fill=head; drop_cnt=drop_cnt+inflight-(rom_rvalid_i?1:0).
  - id_valid_o=0 in the cycle after redirect_i. The first request with redirect_pc_i issues that cycle if (drop_cnt+0)<DEPTH.
  - Back-to-back redirects: the last one wins; drop_cnt accumulates.
- Pointer wrap: modulo DEPTH on index, extra bit distinguishes full from empty.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset with inflight=0 are ignored per the return rules.

Test Plan:
- Reset/first fetch: hold rst=0 then release; ROM zero-wait, data=addr^32'hFFFF_FFFF -> first cycle rom_req_o=1, rom_addr_o=0; id_pc_o=0, id_inst_o=FFFF_FFFF two cycles later; then PCs 4, 8, 12 on consecutive cycles.
- Stall fill: id_ready_i=0 with DEPTH=4 -> exactly 4 grants (PCs 0..12), count_o=4, rom_req_o=0. Release id_ready_i -> 0, 4, 8, 12 drain in order; issue resumes at PC 16.
- Variable latency: gnt every cycle, rvalid delayed 3 cycles -> at most 4 outstanding; instructions delivered in order with correct PCs; no loss.
- Redirect with 3 in flight: redirect_i=1, redirect_pc_i=32'h0000_0100 -> drop_cnt=3; the next 3 rvalids are discarded; first delivered id_pc_o=0x100 with its own data.
- Redirect coincident with rvalid and id_ready_i=1: head unchanged by the pop; drop_cnt=inflight-1; no stale instruction appears after the redirect.
- Async reset mid-stream: assert rst between clock edges with 2 entries filled -> id_valid_o, rom_req_o and count_o go to 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: pipelined instruction fetch with an in-order ring of DEPTH entries and redirect flush
module if_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_req_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic                       rom_gnt_i,
  input  logic                       rom_rvalid_i,
  input  logic [DATA_W-1:0]          rom_rdata_i,
  output logic                       id_valid_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  input  logic                       id_ready_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0] alloc, fill, head, drop_cnt, inflight, filled;
  logic [PW:0] pending;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic grant, take, pop, rv_drop;
  assign inflight = alloc - fill;
  assign filled = fill - head;
  assign count_o = alloc - head;
  // responses still owed by the ROM, including ones already flushed by a redirect
  assign pending = {1'b0, drop_cnt} + {1'b0, inflight};
  assign rom_req_o = rst && !redirect_i && count_o < PW'(DEPTH) && pending < (PW+1)'(DEPTH);
  assign rom_addr_o = fetch_pc;
  assign grant = rom_req_o && rom_gnt_i;
  assign rv_drop = rom_rvalid_i && drop_cnt != '0;
  assign take = !redirect_i && rom_rvalid_i && drop_cnt == '0 && inflight != '0;
  assign id_valid_o = filled != '0;
  assign pop = !redirect_i && id_valid_o && id_ready_i;
  assign id_pc_o = id_valid_o ? pc_mem[head[IW-1:0]] : '0;
  assign id_inst_o = id_valid_o ? inst_mem[head[IW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      alloc <= '0;
      fill <= '0;
      head <= '0;
      drop_cnt <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      alloc <= head;
      fill <= head;
      drop_cnt <= PW'(pending - (PW+1)'(rom_rvalid_i && pending != '0));
    end else begin
      if (grant) alloc <= alloc + PW'(1);
      if (grant) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      if (take) fill <= fill + PW'(1);
      if (rv_drop) drop_cnt <= drop_cnt - PW'(1);
      if (pop) head <= head + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (grant) pc_mem[alloc[IW-1:0]] <= fetch_pc;
    if (take) inst_mem[fill[IW-1:0]] <= rom_rdata_i;
  end
endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: randomized fetch-buffer bench against a queue-based model of requests and deliveries
module tb_if_fetch_buf;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic rom_req_o, rom_gnt_i = 0, rom_rvalid_i = 0, id_valid_o, id_ready_i = 0, redirect_i = 0;
  logic [31:0] rom_addr_o, rom_rdata_i = 0, id_pc_o, id_inst_o, redirect_pc_i = 0;
  logic [2:0] count_o;
  always #5 clk = ~clk;
  if_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
    .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_ready_i(id_ready_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .count_o(count_o)
  );
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] pc; logic [31:0] data; int t; bit live;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  req_t out_q[$];
  ent_t rdy_q[$];
  logic [31:0] ref_pc;
  int cyc;
  bit rnd_data;
  bit s_gnt, s_ready, s_redir, s_rv;
  logic [31:0] s_rpc;
  bit exp_req, exp_valid;
  logic [31:0] exp_pc, exp_inst;
  int exp_cnt;
  task automatic clear_model();
    out_q.delete();
    rdy_q.delete();
    ref_pc = 0;
    cyc = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    {rom_gnt_i, rom_rvalid_i, id_ready_i, redirect_i} = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask
  task automatic drive(input bit gnt, input int lat, input bit ready, input bit redir, input logic [31:0] rpc);
    int live = 0;
    s_gnt = gnt; s_ready = ready; s_redir = redir; s_rpc = rpc;
    s_rv = out_q.size() > 0 && (cyc - out_q[0].t) >= lat;
    rom_gnt_i = gnt;
    rom_rvalid_i = s_rv;
    rom_rdata_i = s_rv ? out_q[0].data : $urandom;
    id_ready_i = ready;
    redirect_i = redir;
    redirect_pc_i = rpc;
    foreach (out_q[i]) live += int'(out_q[i].live);
    exp_cnt = live + rdy_q.size();
    exp_req = !redir && exp_cnt < DEPTH && out_q.size() < DEPTH;
    exp_valid = rdy_q.size() > 0;
    exp_pc = exp_valid ? rdy_q[0].pc : 0;
    exp_inst = exp_valid ? rdy_q[0].inst : 0;
    #1;
  endtask
  task automatic advance();
    req_t r;
    @(posedge clk);
    if (s_redir) begin
      if (s_rv) void'(out_q.pop_front());
      foreach (out_q[i]) out_q[i].live = 0;
      rdy_q.delete();
      ref_pc = s_rpc;
    end else begin
      if (exp_valid && s_ready) void'(rdy_q.pop_front());
      if (s_rv) begin
        r = out_q.pop_front();
        if (r.live) rdy_q.push_back('{r.pc, r.data});
      end
      if (exp_req && s_gnt) begin
        out_q.push_back('{ref_pc, ref_pc ^ 32'hFFFF_FFFF ^ (rnd_data ? $urandom : 32'h0), cyc, 1'b1});
        ref_pc += 4;
      end
    end
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    rst = 0;
    rom_gnt_i = 1; id_ready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rom_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", rom_req_o); end
    checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", id_valid_o); end
    checks++; if (id_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc: got %0h want 0", id_pc_o); end
    checks++; if (id_inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst: got %0h want 0", id_inst_o); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count_o); end
  endtask
  task automatic test_first_fetch();
    do_reset();
    rnd_data = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 0, 0);
      if (i == 0) begin
        checks++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin failures++; $display("FAIL first_req: got req=%0b addr=%0h want req=1 addr=0", rom_req_o, rom_addr_o); end
      end
      checks++; if (id_valid_o !== (i >= 2)) begin failures++; $display("FAIL first_valid c%0d: got %0b want %0b", i, id_valid_o, i >= 2); end
      if (i >= 2) begin
        checks++; if (id_pc_o !== 32'(4 * (i - 2)) || id_inst_o !== (32'(4 * (i - 2)) ^ 32'hFFFF_FFFF)) begin failures++; $display("FAIL first_data c%0d: got pc=%0h inst=%0h want pc=%0h", i, id_pc_o, id_inst_o, 4 * (i - 2)); end
      end
      advance();
    end
  endtask
  task automatic test_stall();
    int grants = 0;
    bit seen = 0;
    logic [31:0] first_addr = 0;
    do_reset();
    rnd_data = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 0);
      if (rom_req_o) grants++;
      advance();
    end
    drive(1, 1, 0, 0, 0);
    checks++; if (grants != 4) begin failures++; $display("FAIL stall_grants: got %0d want 4", grants); end
    checks++; if (count_o !== 3'd4 || rom_req_o !== 1'b0) begin failures++; $display("FAIL stall_full: got count=%0d req=%0b want count=4 req=0", count_o, rom_req_o); end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 0, 0);
      checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * k) || id_inst_o !== exp_inst) begin failures++; $display("FAIL stall_drain %0d: got v=%0b pc=%0h inst=%0h want pc=%0h inst=%0h", k, id_valid_o, id_pc_o, id_inst_o, 4 * k, exp_inst); end
      if (rom_req_o && !seen) begin seen = 1; first_addr = rom_addr_o; end
      advance();
    end
    checks++; if (!seen || first_addr !== 32'd16) begin failures++; $display("FAIL stall_resume: got seen=%0b addr=%0h want addr=10", seen, first_addr); end
  endtask
  task automatic test_variable_latency();
    logic [31:0] deliv_pc = 0;
    do_reset();
    rnd_data = 1;
    for (int i = 0; i < 80; i++) begin
      drive(1, 3, $urandom_range(0, 3) != 0, 0, 0);
      checks++; if (rom_req_o !== exp_req) begin failures++; $display("FAIL lat_req c%0d: got %0b want %0b", i, rom_req_o, exp_req); end
      checks++; if (exp_req && rom_addr_o !== ref_pc) begin failures++; $display("FAIL lat_addr c%0d: got %0h want %0h", i, rom_addr_o, ref_pc); end
      checks++; if (id_valid_o !== exp_valid || id_pc_o !== exp_pc || id_inst_o !== exp_inst) begin failures++; $display("FAIL lat_out c%0d: got v=%0b pc=%0h inst=%0h want v=%0b pc=%0h inst=%0h", i, id_valid_o, id_pc_o, id_inst_o, exp_valid, exp_pc, exp_inst); end
      checks++; if (count_o !== 3'(exp_cnt) || count_o > 3'd4) begin failures++; $display("FAIL lat_count c%0d: got %0d want %0d", i, count_o, exp_cnt); end
      if (id_valid_o && s_ready) begin
        checks++; if (id_pc_o !== deliv_pc) begin failures++; $display("FAIL lat_order c%0d: got %0h want %0h", i, id_pc_o, deliv_pc); end
        deliv_pc += 4;
      end
      advance();
    end
    checks++; if (deliv_pc < 32'd40) begin failures++; $display("FAIL lat_throughput: got %0d delivered want >=10", deliv_pc / 4); end
  endtask
  task automatic test_redirect();
    bit found = 0;
    do_reset();
    rnd_data = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 4, 1, 0, 0); advance(); end
    drive(1, 4, 1, 1, 32'h100);
    checks++; if (rom_req_o !== 1'b0) begin failures++; $display("FAIL redir_req: got %0b want 0", rom_req_o); end
    advance();
    for (int i = 0; i < 30 && !found; i++) begin
      drive(1, 4, 1, 0, 0);
      if (i == 0) begin
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL redir_valid: got %0b want 0", id_valid_o); end
      end
      if (id_valid_o) begin
        found = 1;
        checks++; if (id_pc_o !== 32'h100 || id_inst_o !== exp_inst) begin failures++; $display("FAIL redir_first: got pc=%0h inst=%0h want pc=100 inst=%0h", id_pc_o, id_inst_o, exp_inst); end
      end
      advance();
    end
    if (!found) begin checks++; failures++; $display("FAIL redir_timeout: got no delivery want pc=100"); end
  endtask
  task automatic test_redirect_rvalid();
    bit found = 0;
    do_reset();
    rnd_data = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0); advance(); end
    drive(1, 1, 1, 1, 32'h200);
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || rom_req_o !== 1'b0) begin failures++; $display("FAIL rr_cycle: got v=%0b pc=%0h req=%0b want v=1 pc=0 req=0", id_valid_o, id_pc_o, rom_req_o); end
    advance();
    drive(1, 1, 1, 0, 0);
    checks++; if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin failures++; $display("FAIL rr_flush: got v=%0b count=%0d want v=0 count=0", id_valid_o, count_o); end
    checks++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h200) begin failures++; $display("FAIL rr_restart: got req=%0b addr=%0h want req=1 addr=200", rom_req_o, rom_addr_o); end
    advance();
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1, 1, 1, 0, 0);
      if (id_valid_o) begin
        found = 1;
        checks++; if (id_pc_o !== 32'h200 || id_inst_o !== exp_inst) begin failures++; $display("FAIL rr_first: got pc=%0h inst=%0h want pc=200 inst=%0h", id_pc_o, id_inst_o, exp_inst); end
      end
      advance();
    end
    if (!found) begin checks++; failures++; $display("FAIL rr_timeout: got no delivery want pc=200"); end
  endtask
  task automatic test_async_reset();
    do_reset();
    rnd_data = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0); advance(); end
    drive(1, 1, 0, 0, 0);
    checks++; if (id_valid_o !== 1'b1 || count_o !== 3'd3) begin failures++; $display("FAIL ar_pre: got v=%0b count=%0d want v=1 count=3", id_valid_o, count_o); end
    #2 rst = 0;
    #1;
    checks++; if (id_valid_o !== 1'b0 || rom_req_o !== 1'b0 || count_o !== 3'd0) begin failures++; $display("FAIL ar_immediate: got v=%0b req=%0b count=%0d want all 0", id_valid_o, rom_req_o, count_o); end
    clear_model();
    @(posedge clk);
    #1 rst = 1;
    rom_gnt_i = 0; rom_rvalid_i = 1; rom_rdata_i = $urandom;
    #1;
    checks++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin failures++; $display("FAIL ar_restart: got req=%0b addr=%0h want req=1 addr=0", rom_req_o, rom_addr_o); end
    @(posedge clk);
    #1 rom_rvalid_i = 0;
    #1;
    checks++; if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin failures++; $display("FAIL ar_stray: got v=%0b count=%0d want v=0 count=0", id_valid_o, count_o); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0, 0);
      checks++; if (id_valid_o !== exp_valid || id_pc_o !== exp_pc || id_inst_o !== exp_inst) begin failures++; $display("FAIL ar_after c%0d: got v=%0b pc=%0h want v=%0b pc=%0h", i, id_valid_o, id_pc_o, exp_valid, exp_pc); end
      advance();
    end
  endtask
  task automatic test_random();
    do_reset();
    rnd_data = 1;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(1, 5), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
      checks++; if (rom_req_o !== exp_req) begin failures++; $display("FAIL rnd_req c%0d: got %0b want %0b", i, rom_req_o, exp_req); end
      checks++; if (exp_req && rom_addr_o !== ref_pc) begin failures++; $display("FAIL rnd_addr c%0d: got %0h want %0h", i, rom_addr_o, ref_pc); end
      checks++; if (id_valid_o !== exp_valid || id_pc_o !== exp_pc || id_inst_o !== exp_inst) begin failures++; $display("FAIL rnd_out c%0d: got v=%0b pc=%0h inst=%0h want v=%0b pc=%0h inst=%0h", i, id_valid_o, id_pc_o, id_inst_o, exp_valid, exp_pc, exp_inst); end
      checks++; if (count_o !== 3'(exp_cnt)) begin failures++; $display("FAIL rnd_count c%0d: got %0d want %0d", i, count_o, exp_cnt); end
      advance();
    end
  endtask
  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_variable_latency();
    test_redirect();
    test_redirect_rvalid();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
